intflp_limb_scheduler: RTL and testbench

- Sequences the integer-to-floating-point wrapper over all RNS limbs of one polynomial.
- For each limb k:
  - loads that limb's negated modulus and scale power onto the wrapper configuration;
  - releases the wrapper from reset and waits for its done;
  - hands the shared FFT BRAM banks to the FFT engine and waits for that engine's acknowledge before starting limb k+1.
- Sits between the top-level control FSM, the conversion wrapper and the SharedFFTBrams ownership mux.

---
 rtl/intflp_limb_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_intflp_limb_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intflp_limb_scheduler.sv
// Steps the int-to-float conversion wrapper over every RNS limb, then hands the shared FFT BRAMs to the FFT engine.
// Optional RUN watchdog is built when INTFLP_SCHED_TIMEOUT_EN is defined.
module intflp_limb_scheduler #(
    parameter int  NUM_LIMBS_MAX  = 8,
    parameter int  QM_BITS        = 17,
    parameter int  SCALE_BITS     = 12,
    parameter int  SETTLE_CYCLES  = 4,
    parameter int  TIMEOUT_CYCLES = 16384,
    localparam int AW = (NUM_LIMBS_MAX > 1) ? $clog2(NUM_LIMBS_MAX) : 1,
    localparam int NW = $clog2(NUM_LIMBS_MAX) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [QM_BITS-1:0]    cfg_qm,
    input  logic [SCALE_BITS-1:0] cfg_scale,
    input  logic [NW-1:0]         num_limbs,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  wrap_rst,
    output logic [3:0]            wrap_current_k,
    output logic [QM_BITS-1:0]    wrap_q_m,
    output logic [SCALE_BITS-1:0] wrap_scale_power,
    input  logic                  wrap_done,
    output logic                  fft_own,
    output logic                  limb_ready,
    input  logic                  fft_ack
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_RUN     = 3'd2,
        S_HANDOFF = 3'd3,
        S_FINISH  = 3'd4
    } state_e;

    function automatic logic [QM_BITS-1:0] neg_mod(input logic [QM_BITS-1:0] v);
        return {QM_BITS{1'b0}} - v;
    endfunction

    state_e                state_q, state_d;
    logic [AW-1:0]         k_q, k_d;
    logic [NW-1:0]         n_q, n_d, n_clamp_s;
    logic [SW-1:0]         settle_q, settle_d;
    logic                  start_ok_s, zero_done_s, abort_s, tmo_fire_s;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  wrap_rst_q, wrap_rst_d, fft_own_q, fft_own_d, ready_q, ready_d;
    logic [3:0]            cur_k_q, cur_k_d;
    logic [QM_BITS-1:0]    qm_out_q, qm_out_d;
    logic [SCALE_BITS-1:0] sc_out_q, sc_out_d;
    logic [QM_BITS-1:0]    qm_tab_q [NUM_LIMBS_MAX];
    logic [SCALE_BITS-1:0] sc_tab_q [NUM_LIMBS_MAX];

    // Clamp the requested limb count to the table depth.
    always_comb begin
        if (num_limbs > NW'(NUM_LIMBS_MAX)) begin
            n_clamp_s = NW'(NUM_LIMBS_MAX);
        end else begin
            n_clamp_s = num_limbs;
        end
    end

`ifdef INTFLP_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q, tmo_d;

    // Watchdog counts RUN cycles; leaving RUN clears it so every entry starts from zero.
    always_comb begin
        tmo_d      = tmo_q;
        tmo_fire_s = 1'b0;
        if (state_q == S_RUN) begin
            tmo_d = tmo_q + TW'(1);
            if (!wrap_done && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
                tmo_fire_s = 1'b1;
            end else begin
                tmo_fire_s = 1'b0;
            end
        end else begin
            tmo_d = {TW{1'b0}};
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= {TW{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_fire_s = 1'b0;
`endif

    // Next-state logic; abort (or watchdog) from any non-IDLE state overrides everything.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        settle_d    = settle_q;
        start_ok_s  = 1'b0;
        zero_done_s = 1'b0;
        abort_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    start_ok_s = 1'b1;
                    n_d        = n_clamp_s;
                    k_d        = {AW{1'b0}};
                    settle_d   = {SW{1'b0}};
                    if (n_clamp_s == {NW{1'b0}}) begin
                        zero_done_s = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d  = S_RUN;
                    settle_d = {SW{1'b0}};
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_RUN: begin
                if (wrap_done) begin
                    state_d = S_HANDOFF;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HANDOFF: begin
                if (fft_ack) begin
                    k_d      = k_q + AW'(1);
                    settle_d = {SW{1'b0}};
                    if ((NW'(k_q) + NW'(1)) == n_q) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_SETUP;
                    end
                end else begin
                    state_d = S_HANDOFF;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if ((abort || tmo_fire_s) && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            abort_s = 1'b1;
        end else begin
            abort_s = 1'b0;
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        busy_d     = (state_d == S_SETUP) || (state_d == S_RUN) || (state_d == S_HANDOFF);
        done_d     = (state_d == S_FINISH) || zero_done_s;
        wrap_rst_d = (state_d != S_RUN);
        fft_own_d  = (state_d == S_HANDOFF);
        ready_d    = (state_d == S_HANDOFF);
        if (start_ok_s) begin
            err_d = 1'b0;
        end else if (abort_s || (cfg_we && busy_q)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if ((state_d == S_SETUP) && (state_q != S_SETUP)) begin
            cur_k_d  = 4'(k_d);
            qm_out_d = neg_mod(qm_tab_q[k_d]);
            sc_out_d = sc_tab_q[k_d];
        end else begin
            cur_k_d  = cur_k_q;
            qm_out_d = qm_out_q;
            sc_out_d = sc_out_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= {AW{1'b0}};
            n_q        <= {NW{1'b0}};
            settle_q   <= {SW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wrap_rst_q <= 1'b1;
            fft_own_q  <= 1'b0;
            ready_q    <= 1'b0;
            cur_k_q    <= 4'd0;
            qm_out_q   <= {QM_BITS{1'b0}};
            sc_out_q   <= {SCALE_BITS{1'b0}};
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            n_q        <= n_d;
            settle_q   <= settle_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wrap_rst_q <= wrap_rst_d;
            fft_own_q  <= fft_own_d;
            ready_q    <= ready_d;
            cur_k_q    <= cur_k_d;
            qm_out_q   <= qm_out_d;
            sc_out_q   <= sc_out_d;
        end
    end

    // Limb table: contents survive reset, writes are locked out while a sequence runs.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy_q) begin
            qm_tab_q[cfg_addr] <= cfg_qm;
            sc_tab_q[cfg_addr] <= cfg_scale;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
    assign wrap_rst         = wrap_rst_q;
    assign fft_own          = fft_own_q;
    assign limb_ready       = ready_q;
    assign wrap_current_k   = cur_k_q;
    assign wrap_q_m         = qm_out_q;
    assign wrap_scale_power = sc_out_q;
endmodule

// File: tb/tb_intflp_limb_scheduler.sv
// Directed bench for intflp_limb_scheduler: limb sequencing, handoff hold, clamp, abort, locked table, async reset.
module tb_intflp_limb_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [16:0] cfg_qm = 17'd0;
    logic [11:0] cfg_scale = 12'd0;
    logic [3:0]  num_limbs = 4'd0;
    logic        start = 1'b0, abort = 1'b0, wrap_done = 1'b0, fft_ack = 1'b0;
    logic        busy, done, err, wrap_rst, fft_own, limb_ready;
    logic [3:0]  wrap_current_k;
    logic [16:0] wrap_q_m;
    logic [11:0] wrap_scale_power;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [16:0] eqm [8];
    logic [11:0] esc [8];

    intflp_limb_scheduler #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_qm(cfg_qm),
        .cfg_scale(cfg_scale), .num_limbs(num_limbs), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err), .wrap_rst(wrap_rst),
        .wrap_current_k(wrap_current_k), .wrap_q_m(wrap_q_m), .wrap_scale_power(wrap_scale_power),
        .wrap_done(wrap_done), .fft_own(fft_own), .limb_ready(limb_ready), .fft_ack(fft_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [2:0] a, input logic [16:0] q, input logic [11:0] s);
        cfg_we = 1'b1; cfg_addr = a; cfg_qm = q; cfg_scale = s;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] n);
        num_limbs = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Entered while sampling the first SETUP cycle of limb k; leaves after the release of the banks.
    task automatic run_limb(input int k, input logic [16:0] q, input logic [11:0] s, input int hold);
        int cnt;
        logic ok;
        total++;
        if (wrap_current_k !== 4'(k) || wrap_q_m !== q || wrap_scale_power !== s) begin
            bad++;
            $display("FAIL limb%0d_cfg: got k=%0d qm=%h sc=%h, want k=%0d qm=%h sc=%h",
                     k, wrap_current_k, wrap_q_m, wrap_scale_power, k, q, s);
        end
        total++;
        if (busy !== 1'b1 || wrap_rst !== 1'b1 || fft_own !== 1'b0) begin
            bad++;
            $display("FAIL limb%0d_setup: got busy=%b rst=%b own=%b, want 1 1 0", k, busy, wrap_rst, fft_own);
        end
        cnt = 0;
        while (wrap_rst === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        total++;
        if (cnt != 4) begin
            bad++;
            $display("FAIL limb%0d_settle: got %0d cycles, want 4", k, cnt);
        end
        tick(); tick();
        total++;
        if (wrap_rst !== 1'b0 || wrap_q_m !== q) begin
            bad++;
            $display("FAIL limb%0d_run: got rst=%b qm=%h, want 0 %h", k, wrap_rst, wrap_q_m, q);
        end
        wrap_done = 1'b1;
        tick();
        wrap_done = 1'b0;
        total++;
        if (wrap_rst !== 1'b1 || fft_own !== 1'b1 || limb_ready !== 1'b1) begin
            bad++;
            $display("FAIL limb%0d_handoff: got rst=%b own=%b rdy=%b, want 1 1 1", k, wrap_rst, fft_own, limb_ready);
        end
        if (hold > 0) begin
            ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (limb_ready !== 1'b1 || fft_own !== 1'b1 || wrap_rst !== 1'b1) ok = 1'b0;
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL limb%0d_hold: got a drop during %0d-cycle ack wait, want steady 1", k, hold);
            end
        end
        fft_ack = 1'b1;
        tick();
        fft_ack = 1'b0;
        total++;
        if (limb_ready !== 1'b0 || fft_own !== 1'b0) begin
            bad++;
            $display("FAIL limb%0d_release: got rdy=%b own=%b, want 0 0", k, limb_ready, fft_own);
        end
    endtask

    task automatic test_reset;
        tick(); tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || wrap_rst !== 1'b1 ||
            fft_own !== 1'b0 || limb_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: got busy=%b done=%b err=%b rst=%b own=%b rdy=%b, want 0 0 0 1 0 0",
                     busy, done, err, wrap_rst, fft_own, limb_ready);
        end
        total++;
        if (wrap_current_k !== 4'd0 || wrap_q_m !== 17'd0 || wrap_scale_power !== 12'd0) begin
            bad++;
            $display("FAIL reset_cfg: got k=%0d qm=%h sc=%h, want 0 0 0", wrap_current_k, wrap_q_m, wrap_scale_power);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load;
        logic [16:0] qv [8];
        qv = '{17'h1F001, 17'h1E801, 17'h1D001, 17'h1C001, 17'h1B001, 17'h1A001, 17'h19001, 17'h18001};
        eqm = '{17'h00FFF, 17'h017FF, 17'h02FFF, 17'h03FFF, 17'h04FFF, 17'h05FFF, 17'h06FFF, 17'h07FFF};
        esc = '{12'h43E, 12'h43F, 12'h440, 12'h441, 12'h442, 12'h443, 12'h444, 12'h445};
        for (int i = 0; i < 8; i++) write_cfg(3'(i), qv[i], esc[i]);
    endtask

    task automatic test_three_limbs;
        int d0;
        d0 = done_cnt;
        do_start(4'd3);
        run_limb(0, eqm[0], esc[0], 100);
        run_limb(1, eqm[1], esc[1], 0);
        run_limb(2, eqm[2], esc[2], 0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL three_finish: got done=%b busy=%b, want 1 0", done, busy);
        end
        tick();
        total++;
        if (done !== 1'b0 || (done_cnt - d0) != 1) begin
            bad++;
            $display("FAIL three_done_count: got done=%b pulses=%0d, want 0 1", done, done_cnt - d0);
        end
    endtask

    task automatic test_zero_limbs;
        int d0;
        d0 = done_cnt;
        do_start(4'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || wrap_rst !== 1'b1) begin
            bad++;
            $display("FAIL zero_done: got done=%b busy=%b rst=%b, want 1 0 1", done, busy, wrap_rst);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || wrap_rst !== 1'b1 || (done_cnt - d0) != 1) begin
            bad++;
            $display("FAIL zero_after: got done=%b busy=%b rst=%b pulses=%0d, want 0 0 1 1",
                     done, busy, wrap_rst, done_cnt - d0);
        end
    endtask

    task automatic test_clamp;
        int d0;
        d0 = done_cnt;
        do_start(4'd12);
        for (int k = 0; k < 8; k++) run_limb(k, eqm[k], esc[k], 0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clamp_finish: got done=%b busy=%b, want 1 0", done, busy);
        end
        tick();
        total++;
        if ((done_cnt - d0) != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clamp_count: got pulses=%0d busy=%b, want 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_abort;
        int d0;
        int cnt;
        d0 = done_cnt;
        do_start(4'd3);
        run_limb(0, eqm[0], esc[0], 0);
        cnt = 0;
        while (wrap_rst === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || wrap_rst !== 1'b1 || err !== 1'b1 || fft_own !== 1'b0 || limb_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_run: got busy=%b rst=%b err=%b own=%b rdy=%b, want 0 1 1 0 0",
                     busy, wrap_rst, err, fft_own, limb_ready);
        end
        repeat (5) tick();
        total++;
        if (busy !== 1'b0 || (done_cnt - d0) != 0) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b pulses=%0d, want 0 0", busy, done_cnt - d0);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || err !== 1'b1 || (done_cnt - d0) != 0) begin
            bad++;
            $display("FAIL abort_start_clash: got busy=%b err=%b pulses=%0d, want 0 1 0", busy, err, done_cnt - d0);
        end
        do_start(4'd3);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL abort_restart_err: got err=%b, want 0", err);
        end
        for (int k = 0; k < 3; k++) run_limb(k, eqm[k], esc[k], 0);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart_done: got done=%b, want 1", done);
        end
        tick();
    endtask

    task automatic test_cfg_busy;
        do_start(4'd1);
        write_cfg(3'd0, 17'h12345, 12'hABC);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL cfg_busy_err: got err=%b, want 1", err);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        do_start(4'd1);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL cfg_busy_clear: got err=%b, want 0", err);
        end
        run_limb(0, eqm[0], esc[0], 0);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL cfg_busy_done: got done=%b, want 1", done);
        end
        tick();
    endtask

    task automatic test_async_reset;
        int cnt;
        do_start(4'd2);
        cnt = 0;
        while (wrap_rst === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || wrap_rst !== 1'b1 || wrap_q_m !== 17'd0 || wrap_current_k !== 4'd0 ||
            wrap_scale_power !== 12'd0) begin
            bad++;
            $display("FAIL async_reset: got busy=%b rst=%b qm=%h k=%0d sc=%h, want 0 1 0 0 0",
                     busy, wrap_rst, wrap_q_m, wrap_current_k, wrap_scale_power);
        end
        #1 rst_n = 1'b1;
        tick(); tick();
        total++;
        if (busy !== 1'b0 || wrap_rst !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_idle: got busy=%b rst=%b, want 0 1", busy, wrap_rst);
        end
    endtask

`ifdef INTFLP_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        int cnt;
        do_start(4'd1);
        cnt = 0;
        while (wrap_rst === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        repeat (63) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: got busy=%b at RUN cycle 64, want 1", busy);
        end
        tick();
        total++;
        if (busy !== 1'b0 || err !== 1'b1 || wrap_rst !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire: got busy=%b err=%b rst=%b, want 0 1 1", busy, err, wrap_rst);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_three_limbs();
        test_zero_limbs();
        test_clamp();
        test_abort();
        test_cfg_busy();
        test_async_reset();
`ifdef INTFLP_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
